// File: rtl/novacore_pio_pkg.sv
// Shared constants and types for the NovaCORE clock-control PIO.
// Optional irq support is selected by PIO_CLKGEN_IRQ_EN in the top level.
package novacore_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_DIV    = 3'd3;
    localparam logic [2:0] ADDR_BURST  = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_DONE    = 1;
    localparam int unsigned ST_OVERRUN = 2;
    localparam int unsigned ST_IRQ_EN  = 4;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } burst_state_e;

endpackage

// File: rtl/novacore_clk_burst.sv
// Burst engine: emits N pulses of (div+1) cycles high / (div+1) cycles low on clk_out_o.
// done_o is a one-cycle strobe aligned with the edge that ends the burst.
module novacore_clk_burst
    import novacore_pio_pkg::*;
#(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] n_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             clk_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cnt_o
);

    burst_state_e     state_q, state_d;
    logic [DIV_W-1:0] ph_q, ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             zero_q, zero_d;
    logic             last;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        zero_d  = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (n_i != '0) begin
                        cnt_d   = n_i;
                        ph_d    = div_i;
                        state_d = HIGH;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (ph_q == '0) begin
                    ph_d    = div_i;
                    state_d = LOW;
                end else begin
                    ph_d = ph_q - DIV_W'(1);
                end
            end
            LOW: begin
                if (ph_q == '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        last    = 1'b1;
                    end else begin
                        ph_d    = div_i;
                        state_d = HIGH;
                    end
                end else begin
                    ph_d = ph_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        clk_out_d = (state_d == HIGH);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            zero_q    <= zero_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign busy_o    = (state_q != IDLE);
    // A zero-length burst reports done one cycle after its write.
    assign done_o    = last | zero_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/novacore_pio_clkgen.sv
// Avalon-MM PIO with atomic set/clear level outputs and a programmable clock-burst generator.
// Define PIO_CLKGEN_IRQ_EN to add the irq output and the STATUS irq_en bit.
module novacore_pio_clkgen
    import novacore_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned CNT_W       = 24,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             clk_out
`ifdef PIO_CLKGEN_IRQ_EN
   ,output logic             irq
`endif
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             wr, burst_wr, busy, done_pulse;
    logic [CNT_W-1:0] cnt;
    logic             unused_wd;
`ifdef PIO_CLKGEN_IRQ_EN
    logic             irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
`endif

    assign wr        = chipselect && !write_n;
    assign burst_wr  = wr && (address == ADDR_BURST);
    assign unused_wd = ^writedata;

    novacore_clk_burst #(
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) u_burst (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (burst_wr),
        .n_i       (writedata[CNT_W-1:0]),
        .div_i     (div_q),
        .clk_out_o (clk_out),
        .busy_o    (busy),
        .done_o    (done_pulse),
        .cnt_o     (cnt)
    );

    always_comb begin
        data_d    = data_q;
        div_d     = div_q;
        done_d    = done_q;
        overrun_d = overrun_q;
`ifdef PIO_CLKGEN_IRQ_EN
        irq_en_d  = irq_en_q;
        irq_d     = irq_en_q & (done_q | overrun_q);
`endif
        if (wr) begin
            case (address)
                ADDR_DATA: data_d = writedata[WIDTH-1:0];
                ADDR_SET:  data_d = data_q | writedata[WIDTH-1:0];
                ADDR_CLR:  data_d = data_q & ~writedata[WIDTH-1:0];
                ADDR_DIV:  div_d  = writedata[DIV_W-1:0];
                ADDR_STATUS: begin
                    if (writedata[ST_DONE])    done_d    = 1'b0;
                    if (writedata[ST_OVERRUN]) overrun_d = 1'b0;
`ifdef PIO_CLKGEN_IRQ_EN
                    irq_en_d = writedata[ST_IRQ_EN];
`endif
                end
                default: ;
            endcase
        end
        if (burst_wr && busy) overrun_d = 1'b1;
        // Hardware set takes priority over a simultaneous W1C.
        if (done_pulse) done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= RESET_VALUE[WIDTH-1:0];
            div_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PIO_CLKGEN_IRQ_EN
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end else begin
            data_q    <= data_d;
            div_q     <= div_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
`ifdef PIO_CLKGEN_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
`endif
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:  readdata[WIDTH-1:0] = data_q;
            ADDR_DIV:   readdata[DIV_W-1:0] = div_q;
            ADDR_BURST: readdata[CNT_W-1:0] = cnt;
            ADDR_STATUS: begin
                readdata[ST_BUSY]    = busy;
                readdata[ST_DONE]    = done_q;
                readdata[ST_OVERRUN] = overrun_q;
`ifdef PIO_CLKGEN_IRQ_EN
                readdata[ST_IRQ_EN]  = irq_en_q;
`endif
            end
            default: ;
        endcase
    end

    assign out_port = data_q;
`ifdef PIO_CLKGEN_IRQ_EN
    assign irq      = irq_q;
`endif

endmodule

// File: tb/tb_novacore_pio_clkgen.sv
// Scoreboard bench for novacore_pio_clkgen: stimulus queues expectations, a negedge monitor checks.
`timescale 1ns/1ps
module tb_novacore_pio_clkgen;

    localparam logic [2:0] A_DATA = 3'd0, A_SET = 3'd1, A_CLR = 3'd2, A_DIV = 3'd3;
    localparam logic [2:0] A_BURST = 3'd4, A_STATUS = 3'd5;
    localparam int SRC_RD = 0, SRC_OUT = 1, SRC_CLK = 2, SRC_IRQ = 3;
`ifdef PIO_CLKGEN_IRQ_EN
    localparam logic [31:0] IEN = 32'h10;
`else
    localparam logic [31:0] IEN = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        clk_out;
`ifdef PIO_CLKGEN_IRQ_EN
    logic        irq;
`endif

    novacore_pio_clkgen #(
        .WIDTH       (8),
        .DIV_W       (16),
        .CNT_W       (24),
        .RESET_VALUE (32'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .clk_out    (clk_out)
`ifdef PIO_CLKGEN_IRQ_EN
       ,.irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          src;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.src)
                SRC_RD:  act = readdata;
                SRC_OUT: act = {24'b0, out_port};
                SRC_CLK: act = {31'b0, clk_out};
`ifdef PIO_CLKGEN_IRQ_EN
                SRC_IRQ: act = {31'b0, irq};
`endif
                default: act = 32'hDEAD_BEEF;
            endcase
            n_checks++;
            if (act !== e.val) begin
                n_err++;
                $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", e.name, act, e.val, $time);
            end
        end
    end

    task automatic push(input string name, input int src, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.src  = src;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic exp_rd(input string name, input logic [2:0] a, input logic [31:0] val);
        address = a;
        push(name, SRC_RD, val);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        exp_rd("rst_status", A_STATUS, 32'h0);
        push("rst_out_port", SRC_OUT, 32'hA5);
        push("rst_clk_out", SRC_CLK, 32'h0);
        tick();
        exp_rd("rst_data", A_DATA, 32'hA5);
        tick();
        exp_rd("rst_div", A_DIV, 32'h0);
        tick();
        exp_rd("rst_burst", A_BURST, 32'h0);
        tick();

        // DATA / SET / CLR
        push("data_before_wr", SRC_OUT, 32'hA5);
        wr(A_DATA, 32'hFFFF_FF0F);
        push("data_out", SRC_OUT, 32'h0F);
        exp_rd("data_rd", A_DATA, 32'h0F);
        tick();
        wr(A_SET, 32'h0000_00F0);
        push("set_out", SRC_OUT, 32'hFF);
        exp_rd("set_reads_zero", A_SET, 32'h0);
        tick();
        wr(A_CLR, 32'h0000_003C);
        push("clr_out", SRC_OUT, 32'hC3);
        exp_rd("clr_data_rd", A_DATA, 32'hC3);
        tick();
        exp_rd("clr_reads_zero", A_CLR, 32'h0);
        tick();

        // DIV=2, BURST=3: 18 cycles, 3 high / 3 low
        wr(A_DIV, 32'd2);
        exp_rd("div_rd", A_DIV, 32'd2);
        tick();
        wr(A_BURST, 32'd3);
        for (int i = 0; i < 18; i++) begin
            push($sformatf("b3_clk_%0d", i), SRC_CLK, {31'b0, ((i / 3) % 2) == 0});
            if (i % 2 == 0) exp_rd($sformatf("b3_cnt_%0d", i), A_BURST, 32'(3 - i / 6));
            else            exp_rd($sformatf("b3_stat_%0d", i), A_STATUS, 32'h1);
            tick();
        end
        exp_rd("b3_end_status", A_STATUS, 32'h2);
        push("b3_end_clk", SRC_CLK, 32'h0);
        tick();
        exp_rd("b3_end_cnt", A_BURST, 32'h0);
        tick();
        wr(A_STATUS, 32'h2);
        exp_rd("b3_w1c", A_STATUS, 32'h0);
        tick();

        // DIV=0, BURST=5 then BURST=7 while busy
        wr(A_DIV, 32'd0);
        wr(A_BURST, 32'd5);
        push("b5_clk_0", SRC_CLK, 32'h1);
        wr(A_BURST, 32'd7);
        for (int i = 1; i < 10; i++) begin
            push($sformatf("b5_clk_%0d", i), SRC_CLK, {31'b0, (i % 2) == 0});
            if (i % 2 == 0) exp_rd($sformatf("b5_cnt_%0d", i), A_BURST, 32'(5 - i / 2));
            else            exp_rd($sformatf("b5_stat_%0d", i), A_STATUS, 32'h5);
            tick();
        end
        exp_rd("b5_end_status", A_STATUS, 32'h6);
        push("b5_end_clk", SRC_CLK, 32'h0);
        tick();
        push("b5_idle_clk", SRC_CLK, 32'h0);
        tick();
        wr(A_STATUS, 32'h6);
        exp_rd("b5_w1c", A_STATUS, 32'h0);
        tick();

        // Pulse count truncated to 24 bits: 0x01000002 -> 2 pulses
        wr(A_BURST, 32'h0100_0002);
        for (int i = 0; i < 4; i++) begin
            push($sformatf("tr_clk_%0d", i), SRC_CLK, {31'b0, (i % 2) == 0});
            if (i == 0) exp_rd("tr_cnt", A_BURST, 32'd2);
            tick();
        end
        exp_rd("tr_end_status", A_STATUS, 32'h2);
        push("tr_end_clk", SRC_CLK, 32'h0);
        tick();
        wr(A_STATUS, 32'h2);

        // Mid-burst DIV change 1 -> 4, then reset mid-burst
        wr(A_DIV, 32'd1);
        wr(A_BURST, 32'd3);
        push("dv_clk_0", SRC_CLK, 32'h1);
        wr(A_DIV, 32'd4);
        for (int i = 1; i < 10; i++) begin
            push($sformatf("dv_clk_%0d", i), SRC_CLK, {31'b0, (i < 2) || (i >= 7 && i < 12)});
            if (i % 2 == 0) exp_rd($sformatf("dv_cnt_%0d", i), A_BURST, (i < 7) ? 32'd3 : 32'd2);
            else            exp_rd($sformatf("dv_stat_%0d", i), A_STATUS, 32'h1);
            tick();
        end
        reset = 1'b1;
        push("dv_clk_10", SRC_CLK, 32'h1);
        tick();
        reset = 1'b0;
        push("mr_clk", SRC_CLK, 32'h0);
        push("mr_out_port", SRC_OUT, 32'hA5);
        exp_rd("mr_status", A_STATUS, 32'h0);
        tick();
        exp_rd("mr_cnt", A_BURST, 32'h0);
        tick();
        push("mr_clk_late", SRC_CLK, 32'h0);
        exp_rd("mr_status_late", A_STATUS, 32'h0);
        tick();

        // BURST=0: no pulses, done after one cycle; irq when enabled
        wr(A_STATUS, 32'h10);
        exp_rd("ien_rd", A_STATUS, IEN);
        tick();
        wr(A_BURST, 32'd0);
        push("z_clk_0", SRC_CLK, 32'h0);
        exp_rd("z_status_0", A_STATUS, IEN);
`ifdef PIO_CLKGEN_IRQ_EN
        push("z_irq_0", SRC_IRQ, 32'h0);
`endif
        tick();
        push("z_clk_1", SRC_CLK, 32'h0);
        exp_rd("z_status_1", A_STATUS, IEN | 32'h2);
`ifdef PIO_CLKGEN_IRQ_EN
        push("z_irq_1", SRC_IRQ, 32'h0);
`endif
        tick();
        push("z_clk_2", SRC_CLK, 32'h0);
`ifdef PIO_CLKGEN_IRQ_EN
        push("z_irq_2", SRC_IRQ, 32'h1);
`endif
        tick();
        wr(A_STATUS, IEN | 32'h2);
        exp_rd("z_w1c", A_STATUS, IEN);
`ifdef PIO_CLKGEN_IRQ_EN
        push("z_irq_w1c", SRC_IRQ, 32'h1);
`endif
        tick();
`ifdef PIO_CLKGEN_IRQ_EN
        push("z_irq_clear", SRC_IRQ, 32'h0);
`endif
        push("z_clk_end", SRC_CLK, 32'h0);
        tick();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
